// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the boot loader and its neighbours.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses LEN/words/XOR-checksum byte stream, writes big-endian words
// from address 0 and releases the core only after the checksum verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  imem_loader_if.slave          bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t              state, state_nxt;
  logic                xfer;
  logic [15:0]         len_p0;
  logic [23:0]         asm_p0;
  logic [7:0]          csum;
  logic [1:0]          idx;
  logic [ADDR_WIDTH:0] wc_inc;

  function automatic logic len_overflow(input logic [15:0] len);
    return {1'b0, len} > CAP;
  endfunction

  function automatic logic last_word(input logic [ADDR_WIDTH:0] wc, input logic [15:0] len);
    return {{(16-ADDR_WIDTH){1'b0}}, wc} == {1'b0, len};
  endfunction

  assign xfer   = bus.in_valid && bus.in_ready;
  assign wc_inc = word_count + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    cpu_hold     = 1'b1;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_overflow({len_p0[15:8], bus.in_data}))  state_nxt = S_ERR;
          else if ({len_p0[15:8], bus.in_data} == 16'd0) state_nxt = S_CHK;
          else                                            state_nxt = S_DATA;
        end
      end
      S_DATA: if (xfer && idx == 2'd3 && last_word(wc_inc, len_p0)) state_nxt = S_CHK;
      S_CHK: begin
        if (xfer) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Handshake and status are pure decodes of the registered state.
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Stage p0: header and partial-word assembly; no reset needed, always rewritten before use.
  always_ff @(posedge clk) begin
    if (xfer && state == S_LEN_HI) len_p0[15:8] <= bus.in_data;
    if (xfer && state == S_LEN_LO) len_p0[7:0]  <= bus.in_data;
    if (xfer && state == S_DATA)   asm_p0       <= {asm_p0[15:0], bus.in_data};
  end

  // Stage p1: checksum accumulation, byte index and the registered memory write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum           <= 8'd0;
      idx            <= 2'd0;
      word_count     <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            csum       <= 8'd0;
            idx        <= 2'd0;
            word_count <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ bus.in_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_count[ADDR_WIDTH-1:0];
              bus.imem_wdata <= {asm_p0, bus.in_data};
              word_count     <= wc_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus hand-written timing/reset sequences.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          cpu_hold, busy, done, error;
  logic [AW:0]   word_count;

  imem_loader_if #(.ADDR_WIDTH(AW)) ifc ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (ifc.slave),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  typedef struct {
    string       name;
    logic [95:0] bytes;   // stream, first byte in [95:88]
    int          n;
    bit          gaps;
    logic        exp_done;
    logic        exp_err;
    int          exp_wc;
    int          exp_nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        tv[7];
  int          checks   = 0;
  int          failures = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.imem_we) begin
      wa.push_back(ifc.imem_addr);
      wd.push_back(ifc.imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      ifc.in_valid = 1'b0;
      @(negedge clk);
    end
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit do_start);
    int gap;
    wa.delete();
    wd.delete();
    if (do_start) pulse_start();
    for (int i = 0; i < v.n; i++) begin
      gap = v.gaps ? int'($urandom_range(0, 3)) : 0;
      send_byte(v.bytes[95-8*i -: 8], gap);
    end
    chk({v.name, ".done"},     32'(done),     32'(v.exp_done));
    chk({v.name, ".error"},    32'(error),    32'(v.exp_err));
    chk({v.name, ".cpu_hold"}, 32'(cpu_hold), 32'(!v.exp_done));
    chk({v.name, ".in_ready"}, 32'(ifc.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk({v.name, ".word_count"}, 32'(word_count), 32'(v.exp_wc));
    chk({v.name, ".nwrites"},    32'(wa.size()),  32'(v.exp_nw));
    if (v.exp_nw > 0 && wa.size() > 0) begin
      chk({v.name, ".addr0"}, 32'(wa[0]), 32'd0);
      chk({v.name, ".data0"}, wd[0], v.w0);
    end
    if (v.exp_nw > 1 && wa.size() > 1) begin
      chk({v.name, ".addr1"}, 32'(wa[1]), 32'd1);
      chk({v.name, ".data1"}, wd[1], v.w1);
    end
  endtask

  initial begin
    tv[0] = '{"two_word",   96'h00022008_00058C09_0000A800, 11, 1'b0, 1'b1, 1'b0, 2, 2, 32'h20080005, 32'h8C090000};
    tv[1] = '{"bad_chk",    96'h00022008_00058C09_0000A900, 11, 1'b0, 1'b0, 1'b1, 2, 2, 32'h20080005, 32'h8C090000};
    tv[2] = '{"len_0101",   96'h01010000_00000000_00000000,  2, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0,        32'h0};
    tv[3] = '{"len_zero",   96'h00000000_00000000_00000000,  3, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0,        32'h0};
    tv[4] = '{"gappy",      96'h00022008_00058C09_0000A800, 11, 1'b1, 1'b1, 1'b0, 2, 2, 32'h20080005, 32'h8C090000};
    tv[5] = '{"one_word",   96'h0001DEAD_BEEF2200_00000000,  7, 1'b0, 1'b1, 1'b0, 1, 1, 32'hDEADBEEF, 32'h0};
    tv[6] = '{"len_0200",   96'h02000000_00000000_00000000,  2, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0,        32'h0};

    reset        = 1'b0;
    start        = 1'b0;
    ifc.in_data  = 8'h00;
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst.in_ready",   32'(ifc.in_ready),  32'd0);
    chk("rst.imem_we",    32'(ifc.imem_we),   32'd0);
    chk("rst.imem_addr",  32'(ifc.imem_addr), 32'd0);
    chk("rst.imem_wdata", ifc.imem_wdata,     32'd0);
    chk("rst.cpu_hold",   32'(cpu_hold),      32'd1);
    chk("rst.busy",       32'(busy),          32'd0);
    chk("rst.done",       32'(done),          32'd0);
    chk("rst.error",      32'(error),         32'd0);
    chk("rst.word_count", 32'(word_count),    32'd0);

    reset = 1'b1;
    @(negedge clk);

    // Start latency and per-word write strobe timing on the 2-word image.
    start = 1'b1;
    #1 chk("start.ready_same_cycle", 32'(ifc.in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("start.ready_next", 32'(ifc.in_ready), 32'd1);
    chk("start.busy",       32'(busy),         32'd1);
    wa.delete();
    wd.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    chk("w0.we_early", 32'(ifc.imem_we), 32'd0);
    send_byte(8'h05, 0);
    chk("w0.we",    32'(ifc.imem_we),   32'd1);
    chk("w0.addr",  32'(ifc.imem_addr), 32'd0);
    chk("w0.data",  ifc.imem_wdata,     32'h20080005);
    chk("w0.wc",    32'(word_count),    32'd1);
    send_byte(8'h8C, 0);
    chk("w0.we_drop",   32'(ifc.imem_we),   32'd0);
    chk("w0.data_hold", ifc.imem_wdata,     32'h20080005);
    send_byte(8'h09, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("w1.we",        32'(ifc.imem_we),   32'd1);
    chk("w1.addr",      32'(ifc.imem_addr), 32'd1);
    chk("w1.data",      ifc.imem_wdata,     32'h8C090000);
    chk("w1.ready_chk", 32'(ifc.in_ready),  32'd1);
    send_byte(8'hA8, 0);
    chk("seq.done",     32'(done),     32'd1);
    chk("seq.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("seq.nwrites",  32'(wa.size()), 32'd2);

    for (int i = 0; i < 7; i++) run_vec(tv[i], 1'b1);

    // Asynchronous reset mid-load after 5 data bytes, then a clean reload.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    send_byte(8'h8C, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid.in_ready",   32'(ifc.in_ready),  32'd0);
    chk("mid.imem_we",    32'(ifc.imem_we),   32'd0);
    chk("mid.imem_addr",  32'(ifc.imem_addr), 32'd0);
    chk("mid.imem_wdata", ifc.imem_wdata,     32'd0);
    chk("mid.cpu_hold",   32'(cpu_hold),      32'd1);
    chk("mid.busy",       32'(busy),          32'd0);
    chk("mid.word_count", 32'(word_count),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    wa.delete();
    ifc.in_data  = 8'hFF;
    ifc.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("idle.ignore_wc",  32'(word_count), 32'd0);
    chk("idle.ignore_wr",  32'(wa.size()),  32'd0);
    chk("idle.ignore_err", 32'(error),      32'd0);
    run_vec(tv[0], 1'b1);

    // Restart from DONE re-asserts cpu_hold on the next cycle, then reload a 1-word image.
    start = 1'b1;
    #1 chk("redo.hold_before", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("redo.hold_next", 32'(cpu_hold), 32'd1);
    chk("redo.done_next", 32'(done),     32'd0);
    run_vec(tv[5], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader sitting directly upstream of the MIPS core. Accepts a byte stream (length header, instruction words, checksum) over a valid/ready handshake and writes big-endian 32-bit words into instruction memory from word address 0. Holds the core in reset via `cpu_hold` until the image is complete and the checksum matches.

## Interface
- `ADDR_WIDTH`, 8, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts byte; transfer when `in_valid && in_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of write.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  high holds the core in reset.
- `busy`  out  1  high in LEN_HI, LEN_LO, DATA, CHK.
- `done`  out  1  image loaded and verified.
- `error`  out  1  length overflow or checksum mismatch.
- `word_count`  out  ADDR_WIDTH+1  words written in current load.

## Operation
- Stream format: LEN[15:8], LEN[7:0], then LEN words of 4 bytes each MSB-first, then 1 checksum byte = XOR of all data bytes (header excluded).
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE: `in_ready`=0, `cpu_hold`=1. `start` -> LEN_HI; clears checksum accumulator, byte index, `word_count`, `done`, `error`.
- LEN_HI: on transfer latch LEN[15:8] -> LEN_LO.
- LEN_LO: on transfer latch LEN[7:0]. LEN > 2**ADDR_WIDTH -> ERR. LEN == 0 -> CHK. Else -> DATA.
- DATA: each transfer shifts byte into 32-bit assembly register (first byte -> [31:24]) and XORs it into checksum; 2-bit byte index increments. On 4th byte: register word, `imem_addr`=`word_count`, pulse `imem_we`, increment `word_count`; after the LEN-th word -> CHK.
- CHK: on transfer compare byte with accumulator. Equal -> DONE, else -> ERR.
- DONE: `done`=1, `cpu_hold`=0, `in_ready`=0. `start` -> LEN_HI with `cpu_hold`=1 and `done`=0 in the following cycle.
- ERR: `error`=1, `cpu_hold`=1, `in_ready`=0; only `start` exits (-> LEN_HI, `error` cleared).
- `start` in LEN_HI/LEN_LO/DATA/CHK is ignored.
- `in_ready` = 1 exactly in LEN_HI, LEN_LO, DATA, CHK, decoded from registered state. Bytes are never dropped or duplicated; `in_valid` with `in_ready`=0 has no effect.
- Words already written are not undone on ERR or reset.

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0, `word_count`=0.
- Reset assertion mid-load returns to reset values immediately (async); no further writes.
- `start` at cycle t -> `in_ready`=1 at t+1.
- 4th byte of word accepted at t -> `imem_we`=1 with valid addr/data at t+1 only; `word_count` updates at t+1.
- Back-to-back bytes sustained at 1 byte/cycle with no stall, including across word boundaries and the DATA->CHK transition (last data byte at t, checksum byte acceptable at t+1 while final `imem_we` is high).
- Checksum byte accepted at t -> `done`/`cpu_hold` or `error` change at t+1.
- LEN_LO byte accepted at t with overflow -> `error`=1 at t+1, no write ever issued.
- `imem_addr`/`imem_wdata` hold last written values between strobes.

## Test plan
- Reset, `start`, stream 00 02 20 08 00 05 8C 09 00 00 A8 at 1 byte/cycle -> writes 0x20080005 @0 and 0x8C090000 @1, `word_count`=2, `done`=1, `cpu_hold`=0 one cycle after A8.
- Same stream with checksum 0xA9 -> `error`=1, `cpu_hold`=1, `done`=0; both words still written.
- LEN=0x0101 with ADDR_WIDTH=8 -> ERR one cycle after LEN_LO, `imem_we` never asserted; LEN=0x0000 then checksum 00 -> DONE, no writes.
- Randomised `in_valid` gaps on the 2-word stream -> identical writes and result; no byte accepted while `in_ready`=0.
- Drop `reset` after 5 data bytes -> all outputs at reset values; new `start` and full stream load correctly from address 0.
- From DONE, `start` -> `cpu_hold`=1 next cycle; reload 1-word image 00 01 DE AD BE EF 22 -> 0xDEADBEEF @0, `done`=1.
